// File: rtl/mult_seq_if.sv
// Handshake/data bundle between the execute-stage multdiv issue logic and the
// sequential multiplier.
//   ctrl_MULT       start pulse, operands sampled on the same edge
//   data_operandA/B signed operands (two's complement)
//   data_result     low WIDTH bits of the signed product
//   data_exception  product does not fit WIDTH-bit signed (valid with RDY)
//   data_resultRDY  one-cycle completion strobe
//   busy            multiplier is iterating
// master = requester side, slave = multiplier side.
interface mult_seq_if #(parameter int WIDTH = 32);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_seq.sv
// Sequential signed WIDTH x WIDTH shift-and-add multiplier.
// Operates on magnitudes: the multiplicand shifts left and the multiplier
// shifts right one place per cycle, conditionally accumulating into a
// 2*WIDTH accumulator. The sign is reapplied on the final step, when the low
// half and an overflow flag are registered alongside a one-cycle ready strobe.
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-high
//   bus    mult_seq_if.slave (start, operands, result, exception, ready, busy)
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  mult_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH:0]     prod_hi;

  always_comb begin
    // Most negative value negates to itself, which is the correct unsigned
    // magnitude, so no special case is needed.
    mag_a = bus.data_operandA[WIDTH-1] ? ({WIDTH{1'b0}} - bus.data_operandA)
                                       : bus.data_operandA;
    mag_b = bus.data_operandB[WIDTH-1] ? ({WIDTH{1'b0}} - bus.data_operandB)
                                       : bus.data_operandB;

    // Accumulator value after the current RUN step; on the last step this is
    // the final magnitude, so the signed product is formed from it directly.
    acc_step = acc_q + (mplr_q[0] ? mcand_q : {2*WIDTH{1'b0}});
    prod     = neg_q ? ({2*WIDTH{1'b0}} - acc_step) : acc_step;
    prod_hi  = prod[2*WIDTH-1:WIDTH-1];

    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (bus.ctrl_MULT) begin
      // Start or restart from any state; a pending strobe is dropped.
      mcand_d = {{WIDTH{1'b0}}, mag_a};
      mplr_d  = mag_b;
      neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      acc_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          acc_d   = acc_step;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = DONE;
            result_d = prod[WIDTH-1:0];
            // Representable only if the upper half plus the result sign bit
            // are a pure sign extension.
            exc_d    = !((&prod_hi) || !(|prod_hi));
            rdy_d    = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplr_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = (state_q == RUN);

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // All driving and sampling happens 1ns after a rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: full-precision signed product via plain arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    logic [W-1:0] lo;
    logic ovf;
    p   = longint'($signed(a)) * longint'($signed(b));
    lo  = p[W-1:0];
    ovf = (p != longint'($signed(lo)));
    return {ovf, lo};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = W'($urandom_range(0, 65535));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issues one start pulse, scrambles the operand lines afterwards, and waits
  // (bounded) for the ready strobe. lat counts edges after the start edge.
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt,
                         output logic [W-1:0] res, output logic exc,
                         output logic rdy_after);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = 1'b1;
    tick();
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    lat      = 0;
    busy_cnt = 0;
    while (bus.data_resultRDY !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    res = bus.data_result;
    exc = bus.data_exception;
    tick();
    rdy_after = bus.data_resultRDY;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ctrl_MULT = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    tick();
    tick();
    n_tests++; if (bus.data_result !== '0)
      begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.data_result); end
    n_tests++; if (bus.data_exception !== 1'b0)
      begin n_fail++; $display("FAIL reset_exc: got %b expected 0", bus.data_exception); end
    n_tests++; if (bus.data_resultRDY !== 1'b0)
      begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", bus.data_resultRDY); end
    n_tests++; if (bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [W-1:0] res;
    logic exc, ra;
    do_mult(32'd3, 32'd5, lat, bc, res, exc, ra);
    n_tests++; if (lat !== 32)
      begin n_fail++; $display("FAIL basic_latency: got %0d expected 32", lat); end
    n_tests++; if (bc !== 32)
      begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 32", bc); end
    n_tests++; if (res !== 32'd15)
      begin n_fail++; $display("FAIL basic_result: got %h expected %h", res, 32'd15); end
    n_tests++; if (exc !== 1'b0)
      begin n_fail++; $display("FAIL basic_exc: got %b expected 0", exc); end
    n_tests++; if (ra !== 1'b0)
      begin n_fail++; $display("FAIL basic_rdy_width: got %b expected 0", ra); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0001_0000, 32'h7FFF_FFFF,
                             32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0009};
    logic [W-1:0] vb [8] = '{32'd6, 32'hFFFF_FFFA, 32'h0001_0000, 32'd2,
                             32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd9};
    logic [W-1:0] er [8] = '{32'hFFFF_FFD6, 32'd42, 32'h0, 32'hFFFF_FFFE,
                             32'h8000_0000, 32'h8000_0000, 32'h0, 32'd81};
    logic         ee [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      int lat, bc;
      logic [W-1:0] res;
      logic exc, ra;
      do_mult(va[i], vb[i], lat, bc, res, exc, ra);
      n_tests++; if (lat !== 32 || res !== er[i] || exc !== ee[i])
        begin n_fail++; $display("FAIL directed_%0d: got lat=%0d res=%h exc=%b expected lat=32 res=%h exc=%b",
                                 i, lat, res, exc, er[i], ee[i]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int lat, bc;
      logic [W-1:0] a, b, res;
      logic exc, ra;
      logic [W:0] exp_v;
      a = pick_operand();
      b = pick_operand();
      exp_v = model(a, b);
      do_mult(a, b, lat, bc, res, exc, ra);
      n_tests++; if (lat !== 32 || res !== exp_v[W-1:0] || exc !== exp_v[W])
        begin n_fail++; $display("FAIL random_%0d: a=%h b=%h got lat=%0d res=%h exc=%b expected lat=32 res=%h exc=%b",
                                 i, a, b, lat, res, exc, exp_v[W-1:0], exp_v[W]); end
    end
  endtask

  // Restart during RUN: first operation must never complete.
  task automatic test_restart();
    int first_rdy, pulses;
    logic [W-1:0] res;
    bus.data_operandA = 32'd2; bus.data_operandB = 32'd3; bus.ctrl_MULT = 1'b1;
    tick();
    bus.ctrl_MULT = 1'b0;
    repeat (9) tick();
    bus.data_operandA = 32'd4; bus.data_operandB = 32'd5; bus.ctrl_MULT = 1'b1;
    tick();
    bus.ctrl_MULT = 1'b0;
    first_rdy = -1; pulses = 0; res = '0;
    for (int k = 0; k < 40; k++) begin
      if (bus.data_resultRDY === 1'b1) begin
        pulses++;
        if (first_rdy < 0) begin first_rdy = k; res = bus.data_result; end
      end
      tick();
    end
    n_tests++; if (first_rdy !== 32)
      begin n_fail++; $display("FAIL restart_latency: got %0d expected 32", first_rdy); end
    n_tests++; if (pulses !== 1)
      begin n_fail++; $display("FAIL restart_pulses: got %0d expected 1", pulses); end
    n_tests++; if (res !== 32'd20)
      begin n_fail++; $display("FAIL restart_result: got %h expected %h", res, 32'd20); end
  endtask

  // ctrl_MULT held for several edges: the last sampled operands win.
  task automatic test_back_to_back();
    int first_rdy, pulses;
    logic [W-1:0] res, a, b;
    logic exc;
    logic [W:0] exp_v;
    bus.ctrl_MULT = 1'b1;
    bus.data_operandA = 32'd11; bus.data_operandB = 32'd13; tick();
    bus.data_operandA = 32'd17; bus.data_operandB = 32'd19; tick();
    a = pick_operand(); b = $urandom;
    bus.data_operandA = a; bus.data_operandB = b; tick();
    bus.ctrl_MULT = 1'b0;
    exp_v = model(a, b);
    first_rdy = -1; pulses = 0; res = '0; exc = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.data_resultRDY === 1'b1) begin
        pulses++;
        if (first_rdy < 0) begin first_rdy = k; res = bus.data_result; exc = bus.data_exception; end
      end
      tick();
    end
    n_tests++; if (first_rdy !== 32 || pulses !== 1)
      begin n_fail++; $display("FAIL b2b_timing: got first=%0d pulses=%0d expected 32/1", first_rdy, pulses); end
    n_tests++; if (res !== exp_v[W-1:0] || exc !== exp_v[W])
      begin n_fail++; $display("FAIL b2b_result: got %h/%b expected %h/%b", res, exc, exp_v[W-1:0], exp_v[W]); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, pulses;
    logic [W-1:0] res;
    logic exc, ra;
    bus.data_operandA = 32'd9; bus.data_operandB = 32'd9; bus.ctrl_MULT = 1'b1;
    tick();
    bus.ctrl_MULT = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if (bus.data_result !== '0 || bus.data_exception !== 1'b0 ||
                   bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL midreset_outputs: got res=%h exc=%b rdy=%b busy=%b expected all 0",
                               bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy); end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.data_resultRDY === 1'b1) pulses++;
      tick();
    end
    n_tests++; if (pulses !== 0)
      begin n_fail++; $display("FAIL midreset_no_rdy: got %0d pulses expected 0", pulses); end
    do_mult(32'd9, 32'd9, lat, bc, res, exc, ra);
    n_tests++; if (lat !== 32 || res !== 32'd81 || exc !== 1'b0)
      begin n_fail++; $display("FAIL midreset_rerun: got lat=%0d res=%h exc=%b expected 32/%h/0", lat, res, exc, 32'd81); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
